// File: rtl/gpio_in_port.sv
// Input GPIO port for the 6502 bus: synchronizes, debounces and edge-latches board inputs.
// Optional level interrupt output is built only when GPIO_IN_IRQ_EN is defined.
module gpio_in_port #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int CNT_W           = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] pins,
    input  logic             cs,
    input  logic             we,
    input  logic [1:0]       addr,
    input  logic [7:0]       data_in,
    output logic [7:0]       data_out,
    output logic             irq
);

    typedef enum logic [1:0] {
        REG_LEVEL = 2'd0,
        REG_EDGE  = 2'd1,
        REG_POL   = 2'd2,
        REG_MASK  = 2'd3
    } reg_addr_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_level;
    logic [WIDTH-1:0] r_edge;
    logic [WIDTH-1:0] r_pol;
    logic [CNT_W-1:0] r_cnt [WIDTH];

    logic [WIDTH-1:0] w_level_next;
    logic [WIDTH-1:0] w_event;
    logic [WIDTH-1:0] w_wr_data;
    logic [WIDTH-1:0] w_edge_clr;
    logic [CNT_W-1:0] w_cnt_next [WIDTH];
    logic [7:0]       w_rd_data;
    logic             w_wr;
    logic             w_rd;
    reg_addr_e        w_addr;

`ifdef GPIO_IN_IRQ_EN
    logic [WIDTH-1:0] r_mask;
    logic             r_irq;
`endif

    assign w_wr       = cs && we;
    assign w_rd       = cs && !we;
    assign w_addr     = reg_addr_e'(addr);
    assign w_wr_data  = data_in[WIDTH-1:0];
    assign w_edge_clr = (w_wr && w_addr == REG_EDGE) ? w_wr_data : '0;

    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_level_next = r_level;
        for (int i = 0; i < WIDTH; i++) begin
            w_cnt_next[i] = '0;
            if (r_sync2[i] != r_level[i]) begin
                if (r_cnt[i] >= CNT_LAST) begin
                    w_level_next[i] = ~r_level[i];
                end else if (r_cnt[i] != CNT_MAX) begin
                    w_cnt_next[i] = r_cnt[i] + 1'b1;
                end else begin
                    w_cnt_next[i] = r_cnt[i];
                end
            end
        end
        // POL selects which direction counts as an event: 0 = rising, 1 = falling.
        w_event = (w_level_next & ~r_level & ~r_pol) | (~w_level_next & r_level & r_pol);
    end

    always_comb begin
        w_rd_data = 8'h00;
        case (w_addr)
            REG_LEVEL: w_rd_data = 8'(r_level);
            REG_EDGE:  w_rd_data = 8'(r_edge);
            REG_POL:   w_rd_data = 8'(r_pol);
`ifdef GPIO_IN_IRQ_EN
            REG_MASK:  w_rd_data = 8'(r_mask);
`else
            REG_MASK:  w_rd_data = 8'h00;
`endif
            default:   w_rd_data = 8'h00;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_level  <= '0;
            r_edge   <= '0;
            r_pol    <= '0;
            data_out <= 8'h00;
            // NOTE: the counter array is a small bank of flops, not RAM, so it can and must be reset element by element.
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= pins;
            r_sync2 <= r_sync1;
            r_level <= w_level_next;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= w_cnt_next[i];
            end
            // A new event beats a simultaneous write-1-to-clear of the same bit.
            r_edge <= (r_edge & ~w_edge_clr) | w_event;
            if (w_wr && w_addr == REG_POL) begin
                r_pol <= w_wr_data;
            end
            if (w_rd) begin
                data_out <= w_rd_data;
            end
        end
    end

`ifdef GPIO_IN_IRQ_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mask <= '0;
            r_irq  <= 1'b0;
        end else begin
            if (w_wr && w_addr == REG_MASK) begin
                r_mask <= w_wr_data;
            end
            r_irq <= |(r_edge & r_mask);
        end
    end

    assign irq = r_irq;
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_in_port.sv
// Self-checking bench for gpio_in_port (DEBOUNCE_CYCLES=4, WIDTH=8), directed steps plus random traffic.
// Expected values come from a cycle-level reference model; build with GPIO_IN_IRQ_EN to cover the interrupt.
module tb_gpio_in_port;

    localparam int W   = 8;
    localparam int DEB = 4;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] pins    = 8'h00;
    logic       cs      = 1'b0;
    logic       we      = 1'b0;
    logic [1:0] addr    = 2'd0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic       irq;

    int checks   = 0;
    int failures = 0;

    // Reference model state: a two-deep pin delay queue, per-bit run lengths, and the register file.
    logic [7:0] m_pipe[$];
    int         m_run[W];
    logic [7:0] m_level, m_edge, m_pol, m_mask, m_dout;
    logic       m_irq;

`ifdef GPIO_IN_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    gpio_in_port #(.WIDTH(W), .DEBOUNCE_CYCLES(DEB), .CNT_W(3)) dut (
        .clk(clk), .reset_n(reset_n), .pins(pins), .cs(cs), .we(we),
        .addr(addr), .data_in(data_in), .data_out(data_out), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_pipe = {8'h00, 8'h00};
        for (int i = 0; i < W; i++) m_run[i] = 0;
        m_level = 8'h00; m_edge = 8'h00; m_pol = 8'h00; m_mask = 8'h00;
        m_dout  = 8'h00; m_irq  = 1'b0;
    endtask

    // A bit flips once its delayed pin value has disagreed with LEVEL for DEB consecutive cycles.
    function automatic logic [7:0] m_toggles();
        logic [7:0] s;
        logic [7:0] t;
        s = m_pipe[0];
        t = 8'h00;
        for (int i = 0; i < W; i++) t[i] = (s[i] != m_level[i]) && (m_run[i] + 1 >= DEB);
        return t;
    endfunction

    // Advance model and DUT one clock with the currently driven inputs, then compare outputs.
    task automatic tick();
        logic [7:0] s, tog, ev, clr;
        if (!reset_n) begin
            m_reset();
        end else begin
            s   = m_pipe[0];
            tog = m_toggles();
            ev  = tog & ~(m_level ^ m_pol);
            for (int i = 0; i < W; i++)
                m_run[i] = (s[i] != m_level[i] && !tog[i]) ? m_run[i] + 1 : 0;
            if (cs && !we) begin
                case (addr)
                    2'd0: m_dout = m_level;
                    2'd1: m_dout = m_edge;
                    2'd2: m_dout = m_pol;
                    default: m_dout = IRQ_ON ? m_mask : 8'h00;
                endcase
            end
            m_irq = IRQ_ON && ((m_edge & m_mask) != 8'h00);
            clr = (cs && we && addr == 2'd1) ? data_in : 8'h00;
            if (cs && we && addr == 2'd2) m_pol = data_in;
            if (cs && we && addr == 2'd3 && IRQ_ON) m_mask = data_in;
            m_edge  = (m_edge & ~clr) | ev;
            m_level = m_level ^ tog;
            void'(m_pipe.pop_front());
            m_pipe.push_back(pins);
        end
        @(posedge clk);
        #1;
        check("data_out", data_out, m_dout);
        check("irq", {7'd0, irq}, {7'd0, m_irq});
    endtask

    task automatic idle(input int n);
        cs = 1'b0; we = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic rd(input logic [1:0] a);
        cs = 1'b1; we = 1'b0; addr = a;
        tick();
        cs = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        cs = 1'b1; we = 1'b1; addr = a; data_in = d;
        tick();
        cs = 1'b0; we = 1'b0;
    endtask

    initial begin
        int  n;
        logic [7:0] exp_mask;

        // Reset state: every register reads zero, irq low.
        m_reset();
        #12;
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("rst_irq", {7'd0, irq}, 8'h00);
        for (int a = 0; a < 4; a++) begin
            rd(2'(a));
            check("rst_reg", data_out, 8'h00);
        end

        // Rising edge on pin 0: LEVEL flips exactly 2+DEB edges after the change.
        pins = 8'h01;
        idle(5);
        rd(2'd0);  check("lvl0_early", data_out, 8'h00);
        rd(2'd0);  check("lvl0_set", data_out, 8'h01);
        rd(2'd1);  check("edge0_set", data_out, 8'h01);

        // A 3-cycle pulse on pin 1 is filtered out.
        pins = 8'h03; idle(3);
        pins = 8'h01; idle(8);
        rd(2'd0);  check("glitch_lvl", data_out, 8'h01);
        rd(2'd1);  check("glitch_edge", data_out, 8'h01);

        // Falling-edge polarity on pin 1, then write-1-to-clear.
        pins = 8'h03; idle(8);
        wr(2'd1, 8'h02);
        wr(2'd2, 8'h02);
        rd(2'd1);  check("pol_noevent", data_out, 8'h01);
        pins = 8'h01; idle(8);
        rd(2'd1);  check("fall_edge", data_out, 8'h03);
        wr(2'd1, 8'h02);
        rd(2'd1);  check("w1c", data_out, 8'h01);

        // Interrupt path and set-beats-clear on the same cycle.
        wr(2'd3, 8'h01);
        exp_mask = IRQ_ON ? 8'h01 : 8'h00;
        rd(2'd3);  check("mask_rd", data_out, exp_mask);
        check("irq_on", {7'd0, irq}, {7'd0, IRQ_ON});
        wr(2'd1, 8'h01);
        idle(2);
        check("irq_cleared", {7'd0, irq}, 8'h00);
        pins = 8'h00; idle(8);
        pins = 8'h01;
        n = 0;
        while (m_toggles()[0] == 1'b0 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (n >= 20) begin
            failures++;
            $error("FAIL event_wait observed=timeout expected=event");
        end
        wr(2'd1, 8'h01);
        rd(2'd1);  check("set_wins", data_out, 8'h01);
        check("irq_held", {7'd0, irq}, {7'd0, IRQ_ON});

        // Random pin activity and bus traffic against the model.
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(7) == 0) pins = 8'($urandom);
            cs      = ($urandom_range(2) == 0);
            we      = 1'($urandom);
            addr    = 2'($urandom);
            data_in = 8'($urandom);
            tick();
        end
        idle(1);

        // Drive EDGE to 0xFF, then assert reset asynchronously mid-debounce.
        wr(2'd2, 8'h00);
        pins = 8'h00; idle(10);
        wr(2'd1, 8'hFF);
        wr(2'd3, 8'hFF);
        pins = 8'hFF; idle(10);
        rd(2'd1);  check("edge_all", data_out, 8'hFF);
        pins = 8'h00; idle(3);
        #2;
        reset_n = 1'b0;
        m_reset();
        #1;
        check("async_dout", data_out, 8'h00);
        check("async_irq", {7'd0, irq}, 8'h00);
        pins = 8'hFF;
        tick();
        #3;
        reset_n = 1'b1;
        idle(5);
        rd(2'd0);  check("post_rst_early", data_out, 8'h00);
        rd(2'd0);  check("post_rst_lvl", data_out, 8'hFF);
        rd(2'd1);  check("post_rst_edge", data_out, 8'hFF);
        rd(2'd3);  check("post_rst_mask", data_out, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
